discharge_pulse_timer: RTL and testbench
========================================

# discharge_pulse_timer

Pulse sequencer that drives the buck discharge setpoint path. It produces the Ton/Toff pulse train and the in-pulse time base `timer_buck_interleave`, which is 0 outside Ton and counts 1..Ton inside it. It also provides shadow-latched `waveform`, `Ton_timer` and `Ip`, so the downstream setpoint generator sees parameters that are stable for a whole pulse. It sits between the host configuration registers and the i_set / current-loop logic in `discharge_control`.

## Interface
- `TIMER_W`, 32, width of Ton/Toff/timer values
- `CNT_W`, 16, width of pulse count fields
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to begin a pulse train
- `stop`  in  1  one-cycle request to abort immediately
- `waveform_in`  in  16  requested waveform; legal values 0x0001 rect, 0x0002 tri, 0x8000 resistor
- `Ton_in`  in  TIMER_W  requested on-time in clk cycles
- `Toff_in`  in  TIMER_W  requested off-time in clk cycles
- `Ip_in`  in  16  requested peak current
- `pulse_num`  in  CNT_W  number of pulses; 0 means continuous
- `waveform`  out  16  shadow waveform, reset 0
- `Ton_timer`  out  TIMER_W  shadow on-time, reset 0
- `Ip`  out  16  shadow peak current, reset 0
- `timer_buck_interleave`  out  TIMER_W  in-pulse time base, reset 0
- `discharge_on`  out  1  high during Ton, reset 0
- `busy`  out  1  high in ON or OFF, reset 0
- `pulse_done`  out  1  one-cycle strobe at the end of each Toff, reset 0
- `pulse_count`  out  CNT_W  pulses completed since the last accepted start, reset 0
- `cfg_err`  out  1  one-cycle strobe when a configuration is rejected, reset 0

## Operation
- States are IDLE, ON and OFF. `rst` forces IDLE and sets every output to its reset value.
- Config is valid when all of these hold: `Ton_in` ≥ 2, `Toff_in` ≥ 1, and `waveform_in` is one of the three legal values.
- **IDLE**
  - Timer is 0.
  - `start`=1, `stop`=0 and config valid: latch shadows, clear `pulse_count`, go to ON.
  - `start`=1 with invalid config: pulse `cfg_err`, stay in IDLE.
  - `stop` has priority over `start`.
- **ON**
  - Timer increments by 1 each cycle.
  - When timer == `Ton_timer`: go to OFF. Timer becomes 0 and the internal off-counter becomes 1.
- **OFF**
  - Off-counter increments each cycle; timer stays 0.
  - When off-counter == latched Toff:
    - Pulse `pulse_done`.
    - Increment `pulse_count`, saturating at all-ones.
    - If `pulse_num` ≠ 0 and the new count == `pulse_num`: go to IDLE.
    - Otherwise: reload shadows from the inputs if they are valid, else keep the old shadows and pulse `cfg_err`. Then go to ON with timer = 1.
- `stop` in ON or OFF goes to IDLE on the next edge. Timer becomes 0, `discharge_on` becomes 0, and there is no `pulse_done` or count increment. Shadows hold their values.
- `start` while busy is ignored.
- Input changes while busy affect outputs only at the next pulse boundary.
- Comparisons use equality on full TIMER_W; the counters can never wrap.

## Timing
- `start` accepted at edge k: at k+1 the state is ON, timer = 1, `discharge_on` = 1, `busy` = 1, and shadows are valid.
- ON lasts exactly Ton cycles with timer values 1..Ton. OFF lasts exactly Toff cycles with timer 0.
- Period is exactly Ton+Toff cycles with no idle gap between pulses.
- `pulse_done` is high in the first cycle after the last OFF cycle, together with the updated `pulse_count` and either ON (timer = 1) or IDLE.
- `busy` falls in the same cycle that the final `pulse_done` is high.
- `stop` or `rst` at edge k: state is IDLE from k+1.
- All outputs are registered.

## Test plan
- **Finite train.** Ton=5, Toff=3, `pulse_num`=3, waveform 0x0001, Ip=100.
  - Timer runs 1..5 then 0×3; the pattern repeats 3 times.
  - `pulse_done` fires at cycles 9, 17, 25 after start.
  - `pulse_count`=3, `busy`=0 from cycle 25.
- **Continuous mode with parameter update.** `pulse_num`=0, Ton=4.
  - Change `Ton_in` to 6 and `Ip_in` to 200 mid-ON.
  - The current pulse keeps Ton=4 and Ip=100; the next pulse shows `Ton_timer`=6, `Ip`=200.
- **Abort.** `stop` at timer=3 of pulse 2.
  - Next cycle: IDLE, timer 0, `discharge_on` 0, `pulse_count`=1, no `pulse_done`.
- **Invalid config.**
  - `start` with `Ton_in`=1: one-cycle `cfg_err`, `busy` stays 0.
  - `start` with waveform 0x0003: same response.
  - `start` and `stop` in the same cycle: stays IDLE, no `cfg_err`.
- **Reset mid-OFF.** Assert `rst` at off-counter 2.
  - Next cycle all outputs are 0.
  - A new `start` afterwards reproduces the first scenario exactly.

Source files
------------

// File: rtl/discharge_pulse_timer.sv
// discharge_pulse_timer: Ton/Toff pulse sequencer with shadow-latched pulse parameters
module discharge_pulse_timer #(
    parameter int TIMER_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        waveform_in,
    input  logic [TIMER_W-1:0] Ton_in,
    input  logic [TIMER_W-1:0] Toff_in,
    input  logic [15:0]        Ip_in,
    input  logic [CNT_W-1:0]   pulse_num,
    output logic [15:0]        waveform,
    output logic [TIMER_W-1:0] Ton_timer,
    output logic [15:0]        Ip,
    output logic [TIMER_W-1:0] timer_buck_interleave,
    output logic               discharge_on,
    output logic               busy,
    output logic               pulse_done,
    output logic [CNT_W-1:0]   pulse_count,
    output logic               cfg_err
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, off_q, off_d, toff_q, toff_d, ton_q, ton_d;
    logic [15:0] wf_q, wf_d, ip_q, ip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic done_q, done_d, err_q, err_d, on_q, on_d, busy_q, busy_d;
    logic cfg_ok, load;
    assign cfg_ok = Ton_in >= TIMER_W'(2) && Toff_in != '0 &&
                    (waveform_in == 16'h0001 || waveform_in == 16'h0002 || waveform_in == 16'h8000);
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start && !stop) begin
                    load    = cfg_ok;
                    err_d   = !cfg_ok;
                    cnt_d   = cfg_ok ? '0 : cnt_q;
                    state_d = cfg_ok ? ON : IDLE;
                    timer_d = cfg_ok ? TIMER_W'(1) : '0;
                end
            end
            ON: begin
                if (stop) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == ton_q) begin
                    state_d = OFF;
                    timer_d = '0;
                    off_d   = TIMER_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            OFF: begin
                if (stop) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (off_q == toff_q) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_inc;
                    if (pulse_num != '0 && cnt_inc == pulse_num) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        // rejected reload keeps the previous shadows for the next pulse
                        load    = cfg_ok;
                        err_d   = !cfg_ok;
                        state_d = ON;
                        timer_d = TIMER_W'(1);
                    end
                end else begin
                    off_d = off_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        wf_d   = load ? waveform_in : wf_q;
        ton_d  = load ? Ton_in : ton_q;
        toff_d = load ? Toff_in : toff_q;
        ip_d   = load ? Ip_in : ip_q;
        on_d   = state_d == ON;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            off_q   <= '0;
            toff_q  <= '0;
            ton_q   <= '0;
            wf_q    <= '0;
            ip_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            off_q   <= off_d;
            toff_q  <= toff_d;
            ton_q   <= ton_d;
            wf_q    <= wf_d;
            ip_q    <= ip_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
        end
    end
    assign waveform              = wf_q;
    assign Ton_timer             = ton_q;
    assign Ip                    = ip_q;
    assign timer_buck_interleave = timer_q;
    assign discharge_on          = on_q;
    assign busy                  = busy_q;
    assign pulse_done            = done_q;
    assign pulse_count           = cnt_q;
    assign cfg_err               = err_q;
endmodule

// File: tb/tb_discharge_pulse_timer.sv
// tb_discharge_pulse_timer: directed scenarios checked against a pulse-position model
module tb_discharge_pulse_timer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [15:0] waveform_in = 16'h1, Ip_in = 16'd100, pulse_num = 16'd3;
    logic [31:0] Ton_in = 32'd5, Toff_in = 32'd3;
    logic [15:0] waveform, Ip, pulse_count;
    logic [31:0] Ton_timer, timer_buck_interleave;
    logic discharge_on, busy, pulse_done, cfg_err;
    int checks = 0, errors = 0;

    discharge_pulse_timer #(.TIMER_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .waveform_in(waveform_in), .Ton_in(Ton_in), .Toff_in(Toff_in),
        .Ip_in(Ip_in), .pulse_num(pulse_num),
        .waveform(waveform), .Ton_timer(Ton_timer), .Ip(Ip),
        .timer_buck_interleave(timer_buck_interleave), .discharge_on(discharge_on),
        .busy(busy), .pulse_done(pulse_done), .pulse_count(pulse_count), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: position within the current pulse period, 1..Ton+Toff, 0 when idle
    bit m_live = 0, m_go = 0, m_done = 0, m_err = 0;
    longint m_pos = 0, m_ton = 0, m_toff = 0, m_cnt = 0;
    logic [15:0] m_wf = 0, m_ip = 0;

    function automatic bit cfg_valid();
        return Ton_in >= 2 && Toff_in >= 1 && (waveform_in inside {16'h0001, 16'h0002, 16'h8000});
    endfunction

    task automatic m_load();
        m_ton = Ton_in; m_toff = Toff_in; m_wf = waveform_in; m_ip = Ip_in;
    endtask

    always @(posedge clk) begin
        m_done = 0;
        m_err = 0;
        if (rst) begin
            m_live = 1; m_go = 0; m_pos = 0; m_cnt = 0;
            m_ton = 0; m_toff = 0; m_wf = 0; m_ip = 0;
        end else if (!m_go) begin
            if (start && !stop) begin
                if (cfg_valid()) begin
                    m_load(); m_cnt = 0; m_go = 1; m_pos = 1;
                end else m_err = 1;
            end
        end else if (stop) begin
            m_go = 0; m_pos = 0;
        end else if (m_pos == m_ton + m_toff) begin
            m_done = 1;
            if (m_cnt < 65535) m_cnt++;
            if (pulse_num != 0 && m_cnt == pulse_num) begin
                m_go = 0; m_pos = 0;
            end else begin
                if (cfg_valid()) m_load(); else m_err = 1;
                m_pos = 1;
            end
        end else m_pos++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("timer", timer_buck_interleave, (m_go && m_pos <= m_ton) ? m_pos : 0);
            chk("discharge_on", discharge_on, m_go && m_pos <= m_ton);
            chk("busy", busy, m_go);
            chk("pulse_done", pulse_done, m_done);
            chk("cfg_err", cfg_err, m_err);
            chk("pulse_count", pulse_count, m_cnt);
            chk("waveform", waveform, m_wf);
            chk("Ton_timer", Ton_timer, m_ton);
            chk("Ip", Ip, m_ip);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input int ton, input int toff, input int np, input logic [15:0] wf, input int ip);
        Ton_in = ton; Toff_in = toff; pulse_num = 16'(np); waveform_in = wf; Ip_in = 16'(ip);
    endtask

    task automatic run_finite();
        cfg(5, 3, 3, 16'h1, 100);
        start = 1;
        for (int n = 1; n <= 27; n++) begin
            tick();
            start = (n == 3);
            if (n == 1) begin
                chk("fin_t1", timer_buck_interleave, 1); chk("fin_ton", Ton_timer, 5);
                chk("fin_ip", Ip, 100); chk("fin_wf", waveform, 1); chk("fin_busy1", busy, 1);
            end
            if (n == 5) begin chk("fin_t5", timer_buck_interleave, 5); chk("fin_on5", discharge_on, 1); end
            if (n == 6) begin chk("fin_t6", timer_buck_interleave, 0); chk("fin_on6", discharge_on, 0); end
            if (n == 9) begin chk("fin_done9", pulse_done, 1); chk("fin_cnt9", pulse_count, 1); chk("fin_t9", timer_buck_interleave, 1); end
            if (n == 17) begin chk("fin_done17", pulse_done, 1); chk("fin_cnt17", pulse_count, 2); end
            if (n == 24) begin chk("fin_done24", pulse_done, 0); chk("fin_busy24", busy, 1); end
            if (n == 25) begin
                chk("fin_done25", pulse_done, 1); chk("fin_cnt25", pulse_count, 3);
                chk("fin_busy25", busy, 0); chk("fin_t25", timer_buck_interleave, 0);
            end
            if (n == 26) begin chk("fin_done26", pulse_done, 0); chk("fin_busy26", busy, 0); end
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst_busy", busy, 0); chk("rst_cnt", pulse_count, 0); chk("rst_timer", timer_buck_interleave, 0);
        run_finite();
        // continuous train with mid-pulse update, then abort in pulse 2
        cfg(4, 2, 0, 16'h1, 100);
        start = 1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            start = 0;
            stop = (n == 9);
            if (n == 2) begin Ton_in = 6; Ip_in = 200; end
            if (n == 3) begin chk("cont_ton_old", Ton_timer, 4); chk("cont_ip_old", Ip, 100); chk("cont_t3", timer_buck_interleave, 3); end
            if (n == 7) begin
                chk("cont_done", pulse_done, 1); chk("cont_ton_new", Ton_timer, 6);
                chk("cont_ip_new", Ip, 200); chk("cont_t7", timer_buck_interleave, 1);
            end
            if (n == 9) chk("abort_t3", timer_buck_interleave, 3);
            if (n == 10) begin
                chk("abort_busy", busy, 0); chk("abort_t", timer_buck_interleave, 0); chk("abort_on", discharge_on, 0);
                chk("abort_cnt", pulse_count, 1); chk("abort_done", pulse_done, 0); chk("abort_ton", Ton_timer, 6);
            end
        end
        // rejected configurations
        cfg(1, 3, 3, 16'h1, 100); start = 1; tick(); start = 0;
        chk("bad_ton_err", cfg_err, 1); chk("bad_ton_busy", busy, 0);
        tick(); chk("bad_ton_err_off", cfg_err, 0);
        cfg(5, 3, 3, 16'h3, 100); start = 1; tick(); start = 0;
        chk("bad_wf_err", cfg_err, 1); chk("bad_wf_busy", busy, 0);
        tick();
        cfg(5, 0, 3, 16'h8000, 100); start = 1; tick(); start = 0;
        chk("bad_toff_err", cfg_err, 1);
        tick();
        cfg(5, 3, 3, 16'h1, 100); start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("startstop_err", cfg_err, 0); chk("startstop_busy", busy, 0);
        tick();
        // invalid reload at a pulse boundary keeps old shadows
        cfg(2, 1, 0, 16'h2, 50); start = 1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            start = 0;
            stop = (n == 5);
            if (n == 2) waveform_in = 16'h3;
            if (n == 4) begin
                chk("reload_err", cfg_err, 1); chk("reload_wf", waveform, 2);
                chk("reload_busy", busy, 1); chk("reload_t", timer_buck_interleave, 1);
            end
            if (n == 6) chk("reload_stop", busy, 0);
        end
        // reset in the middle of OFF, then a clean rerun
        cfg(5, 3, 3, 16'h1, 100); start = 1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            start = 0;
            rst = (n == 7);
        end
        chk("mrst_t", timer_buck_interleave, 0); chk("mrst_on", discharge_on, 0); chk("mrst_busy", busy, 0);
        chk("mrst_cnt", pulse_count, 0); chk("mrst_wf", waveform, 0); chk("mrst_ton", Ton_timer, 0);
        chk("mrst_ip", Ip, 0); chk("mrst_done", pulse_done, 0); chk("mrst_err", cfg_err, 0);
        run_finite();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
